// File: rtl/cam_capture_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// cam_capture_pkg : pixel-format and FSM encodings for the camera capture engine
// Rev 1.0
//------------------------------------------------------------------------------
package cam_capture_pkg;

  typedef enum logic [1:0] {
    MODE_RGB565 = 2'd0,
    MODE_RGB444 = 2'd1,
    MODE_YUV    = 2'd2,
    MODE_TEST   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ARM        = 3'd1,
    WAIT_FRAME = 3'd2,
    CAPTURE    = 3'd3,
    HOLD       = 3'd4
  } state_e;

  // Input coordinates saturate so an oversize frame can never wrap back in-bounds
  localparam int c_COORD_W = 16;

  function automatic logic [c_COORD_W-1:0] coord_inc(input logic [c_COORD_W-1:0] v);
    return (v == '1) ? v : v + c_COORD_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_pixel_convert.sv
`default_nettype none
//------------------------------------------------------------------------------
// cam_pixel_convert : maps a camera byte pair (or coordinates) to an 8-bit pixel
// Rev 1.0
//------------------------------------------------------------------------------
module cam_pixel_convert
  import cam_capture_pkg::*;
(
  input  mode_e      i_mode,
  input  logic [7:0] i_hi,
  input  logic [5:0] i_lo_top,  // lo[7:2]; lo[1:0] never contributes to a pixel
  input  logic [7:0] i_out_x,
  input  logic [7:0] i_out_y,
  output logic [7:0] o_pixel
);

  always_comb begin
    o_pixel = 8'h00;
    case (i_mode)
      MODE_RGB565: o_pixel = {i_hi[7:5], i_hi[2:0], i_lo_top[2:1]};
      MODE_RGB444: o_pixel = {i_hi[3:1], i_lo_top[5:3], i_lo_top[1:0]};
      MODE_YUV:    o_pixel = i_hi;
      MODE_TEST:   o_pixel = i_out_x ^ i_out_y;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cam_capture_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// cam_capture_ctrl : OV7670-style capture into a row-major frame buffer
// Rev 1.0
//------------------------------------------------------------------------------
module cam_capture_ctrl
  import cam_capture_pkg::*;
#(
  parameter int FRAME_WIDTH  = 176,
  parameter int FRAME_HEIGHT = 144,
  parameter int ADDR_WIDTH   = 15,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  CAPTURE_EN,
  input  logic                  SNAPSHOT,
  input  logic [1:0]            MODE,
  input  logic                  DECIM_EN,
  input  logic                  VSYNC,
  input  logic                  HREF,
  input  logic [7:0]            DATA,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [7:0]            W_DATA,
  output logic                  FRAME_DONE,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT,
  output logic                  BUSY,
  output logic                  OVERFLOW
);

  localparam logic [c_COORD_W-1:0]  c_W        = c_COORD_W'(FRAME_WIDTH);
  localparam logic [c_COORD_W-1:0]  c_H_LAST   = c_COORD_W'(FRAME_HEIGHT - 1);
  localparam logic [ADDR_WIDTH-1:0] c_ROW_STEP = ADDR_WIDTH'(FRAME_WIDTH);

  state_e                 r_state;
  mode_e                  r_mode;
  logic                   r_decim;
  logic                   r_snap;
  logic                   r_phase;
  logic [7:0]             r_hi;
  logic                   r_href_d;
  logic [c_COORD_W-1:0]   r_in_x;
  logic [c_COORD_W-1:0]   r_in_y;
  logic [ADDR_WIDTH-1:0]  r_row_base;
  logic                   r_wen;
  logic [ADDR_WIDTH-1:0]  r_waddr;
  logic [7:0]             r_wdata;
  logic                   r_done;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   r_busy;
  logic                   r_ovf;

  logic [c_COORD_W-1:0]   w_out_x;
  logic [c_COORD_W-1:0]   w_out_y;
  logic                   w_keep;
  logic                   w_row_keep;
  logic                   w_in_bounds;
  logic [7:0]             w_pixel;

  assign w_out_x     = r_decim ? {1'b0, r_in_x[c_COORD_W-1:1]} : r_in_x;
  assign w_out_y     = r_decim ? {1'b0, r_in_y[c_COORD_W-1:1]} : r_in_y;
  assign w_keep      = !r_decim || (!r_in_x[0] && !r_in_y[0]);
  assign w_row_keep  = !r_decim || !r_in_y[0];
  assign w_in_bounds = (w_out_x < c_W) && (w_out_y <= c_H_LAST);

  cam_pixel_convert u_convert (
    .i_mode   (r_mode),
    .i_hi     (r_hi),
    .i_lo_top (DATA[7:2]),
    .i_out_x  (w_out_x[7:0]),
    .i_out_y  (w_out_y[7:0]),
    .o_pixel  (w_pixel)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state    <= IDLE;
      r_mode     <= MODE_RGB565;
      r_decim    <= 1'b0;
      r_snap     <= 1'b0;
      r_phase    <= 1'b0;
      r_hi       <= 8'h00;
      r_href_d   <= 1'b0;
      r_in_x     <= '0;
      r_in_y     <= '0;
      r_row_base <= '0;
      r_wen      <= 1'b0;
      r_waddr    <= '0;
      r_wdata    <= 8'h00;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_wen  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (CAPTURE_EN) begin
            r_state <= ARM;
            r_ovf   <= 1'b0;
          end
        end
        ARM: begin
          if (VSYNC) r_state <= WAIT_FRAME;
        end
        WAIT_FRAME: begin
          r_phase  <= 1'b0;
          r_href_d <= 1'b0;
          if (!VSYNC) begin
            r_mode     <= mode_e'(MODE);
            r_decim    <= DECIM_EN;
            r_snap     <= SNAPSHOT;
            r_in_x     <= '0;
            r_in_y     <= '0;
            r_row_base <= '0;
            r_busy     <= 1'b1;
            r_state    <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (VSYNC) begin
            // Frame end wins over any half pixel still pending
            r_done   <= 1'b1;
            r_cnt    <= r_cnt + CNT_WIDTH'(1);
            r_busy   <= 1'b0;
            r_phase  <= 1'b0;
            r_href_d <= 1'b0;
            if (r_snap)           r_state <= HOLD;
            else if (!CAPTURE_EN) r_state <= IDLE;
            else                  r_state <= WAIT_FRAME;
          end else begin
            r_href_d <= HREF;
            if (HREF) begin
              r_phase <= ~r_phase;
              if (!r_phase) begin
                r_hi <= DATA;
              end else begin
                r_in_x <= coord_inc(r_in_x);
                if (w_keep) begin
                  if (w_in_bounds) begin
                    r_wen   <= 1'b1;
                    r_waddr <= r_row_base + ADDR_WIDTH'(w_out_x);
                    r_wdata <= w_pixel;
                  end else begin
                    r_ovf <= 1'b1;
                  end
                end
              end
            end else begin
              r_phase <= 1'b0;
              r_in_x  <= '0;
              if (r_href_d) begin
                r_in_y <= coord_inc(r_in_y);
                // Row base stops at the last stored row so it never leaves the buffer
                if (w_row_keep && (w_out_y < c_H_LAST))
                  r_row_base <= r_row_base + c_ROW_STEP;
              end
            end
          end
        end
        HOLD: begin
          if (!CAPTURE_EN) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign W_EN       = r_wen;
  assign W_ADDR     = r_waddr;
  assign W_DATA     = r_wdata;
  assign FRAME_DONE = r_done;
  assign FRAME_CNT  = r_cnt;
  assign BUSY       = r_busy;
  assign OVERFLOW   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cam_capture_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_cam_capture_ctrl : directed self-checking bench on a reduced 8x6 frame
// Rev 1.0
//------------------------------------------------------------------------------
module tb_cam_capture_ctrl;

  localparam int FW   = 8;
  localparam int FH   = 6;
  localparam int AW   = 6;
  localparam int CW   = 2;
  localparam int NPIX = FW * FH;

  logic          CLK        = 1'b0;
  logic          RESET_N    = 1'b0;
  logic          CAPTURE_EN = 1'b0;
  logic          SNAPSHOT   = 1'b0;
  logic [1:0]    MODE       = 2'd0;
  logic          DECIM_EN   = 1'b0;
  logic          VSYNC      = 1'b0;
  logic          HREF       = 1'b0;
  logic [7:0]    DATA       = 8'h00;
  logic          W_EN;
  logic [AW-1:0] W_ADDR;
  logic [7:0]    W_DATA;
  logic          FRAME_DONE;
  logic [CW-1:0] FRAME_CNT;
  logic          BUSY;
  logic          OVERFLOW;

  cam_capture_ctrl #(
    .FRAME_WIDTH  (FW),
    .FRAME_HEIGHT (FH),
    .ADDR_WIDTH   (AW),
    .CNT_WIDTH    (CW)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CAPTURE_EN (CAPTURE_EN),
    .SNAPSHOT   (SNAPSHOT),
    .MODE       (MODE),
    .DECIM_EN   (DECIM_EN),
    .VSYNC      (VSYNC),
    .HREF       (HREF),
    .DATA       (DATA),
    .W_EN       (W_EN),
    .W_ADDR     (W_ADDR),
    .W_DATA     (W_DATA),
    .FRAME_DONE (FRAME_DONE),
    .FRAME_CNT  (FRAME_CNT),
    .BUSY       (BUSY),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Write monitor: per-epoch record of what landed in the frame buffer
  int         epoch     = 1;
  int         mon_epoch = 0;
  int         exp_a     = 0;
  int         max_addr  = 0;
  int         last_addr = 0;
  int         wr_cnt    = 0;
  int         done_cnt  = 0;
  int         order_bad = 0;
  int         ovf_wr    = -1;
  logic       ovf_prev  = 1'b0;
  logic [7:0] mem   [64];
  int         wr_ep [64];

  always @(negedge CLK) begin
    if (W_EN) begin
      mon_epoch <= epoch;
      if (int'(W_ADDR) != ((mon_epoch != epoch) ? 0 : exp_a)) order_bad <= order_bad + 1;
      exp_a     <= int'(W_ADDR) + 1;
      max_addr  <= ((mon_epoch != epoch) || (int'(W_ADDR) > max_addr)) ? int'(W_ADDR) : max_addr;
      last_addr <= int'(W_ADDR);
      mem[W_ADDR]   <= W_DATA;
      wr_ep[W_ADDR] <= epoch;
      wr_cnt    <= wr_cnt + 1;
    end
    if (FRAME_DONE) done_cnt <= done_cnt + 1;
    if (OVERFLOW && !ovf_prev) ovf_wr <= wr_cnt;
    ovf_prev <= OVERFLOW;
  end

  int b_wr, b_done, b_ord;

  task automatic begin_test();
    epoch++;
    b_wr   = wr_cnt;
    b_done = done_cnt;
    b_ord  = order_bad;
  endtask

  function automatic int count_bad(input logic [7:0] v, input bit tp);
    int         n;
    logic [7:0] e;
    n = 0;
    for (int a = 0; a < NPIX; a++) begin
      e = tp ? 8'((a % FW) ^ (a / FW)) : v;
      if (wr_ep[a] != epoch || mem[a] !== e) n++;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic vs_high(input int n);
    VSYNC = 1'b1;
    HREF  = 1'b0;
    DATA  = 8'h00;
    repeat (n) tick();
  endtask

  task automatic send_line(input int nbytes, input logic [7:0] hi, input logic [7:0] lo);
    for (int i = 0; i < nbytes; i++) begin
      HREF = 1'b1;
      DATA = (i % 2 == 0) ? hi : lo;
      tick();
    end
    HREF = 1'b0;
    DATA = 8'h00;
    tick();
    tick();
  endtask

  task automatic send_frame(input int px, input int lines, input logic [7:0] hi, input logic [7:0] lo);
    VSYNC = 1'b0;
    tick();
    tick();
    for (int l = 0; l < lines; l++) send_line(2 * px, hi, lo);
    vs_high(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tick();
    tick();
    chk("rst_wen",  W_EN,       0);
    chk("rst_addr", W_ADDR,     0);
    chk("rst_data", W_DATA,     0);
    chk("rst_done", FRAME_DONE, 0);
    chk("rst_cnt",  FRAME_CNT,  0);
    chk("rst_busy", BUSY,       0);
    chk("rst_ovf",  OVERFLOW,   0);
    RESET_N = 1'b1;
    tick();

    // RGB565 full frame: E0/1F -> E3
    begin_test();
    CAPTURE_EN = 1'b1;
    MODE       = 2'd0;
    vs_high(3);
    send_frame(FW, FH, 8'hE0, 8'h1F);
    chk("565_writes", wr_cnt - b_wr,        NPIX);
    chk("565_last",   last_addr,            NPIX - 1);
    chk("565_order",  order_bad - b_ord,    0);
    chk("565_data",   count_bad(8'hE3, 0),  0);
    chk("565_done",   done_cnt - b_done,    1);
    chk("565_cnt",    FRAME_CNT,            1);
    chk("565_ovf",    OVERFLOW,             0);

    // RGB444 with 2:1 decimation of a 16x12 input: 0F/F0 -> FC
    begin_test();
    MODE     = 2'd1;
    DECIM_EN = 1'b1;
    send_frame(2 * FW, 2 * FH, 8'h0F, 8'hF0);
    chk("444_writes", wr_cnt - b_wr,        NPIX);
    chk("444_order",  order_bad - b_ord,    0);
    chk("444_data",   count_bad(8'hFC, 0),  0);
    chk("444_cnt",    FRAME_CNT,            2);
    chk("444_ovf",    OVERFLOW,             0);

    // Oversize 10x7 at RGB565: A5/5A -> B7, clipped, overflow after 8 writes
    begin_test();
    MODE     = 2'd0;
    DECIM_EN = 1'b0;
    send_frame(FW + 2, FH + 1, 8'hA5, 8'h5A);
    chk("ovs_writes", wr_cnt - b_wr,        NPIX);
    chk("ovs_max",    max_addr,             NPIX - 1);
    chk("ovs_order",  order_bad - b_ord,    0);
    chk("ovs_data",   count_bad(8'hB7, 0),  0);
    chk("ovs_ovf",    OVERFLOW,             1);
    chk("ovs_ovf_at", ovf_wr - b_wr,        FW);
    chk("ovs_cnt",    FRAME_CNT,            3);

    // Test pattern x^y; frame counter wraps 3 -> 0
    begin_test();
    MODE = 2'd3;
    send_frame(FW, FH, 8'h55, 8'hAA);
    chk("tp_writes", wr_cnt - b_wr,      NPIX);
    chk("tp_data",   count_bad(8'h00, 1), 0);
    chk("tp_cnt",    FRAME_CNT,          0);

    // Snapshot: three frames sent, one captured, then parked
    begin_test();
    MODE     = 2'd0;
    SNAPSHOT = 1'b1;
    repeat (3) send_frame(FW, FH, 8'hE0, 8'h1F);
    chk("snap_done",   done_cnt - b_done, 1);
    chk("snap_writes", wr_cnt - b_wr,     NPIX);
    chk("snap_cnt",    FRAME_CNT,         1);
    chk("snap_busy",   BUSY,              0);
    CAPTURE_EN = 1'b0;
    tick();
    tick();
    SNAPSHOT   = 1'b0;
    CAPTURE_EN = 1'b1;
    tick();
    chk("rearm_ovf", OVERFLOW, 0);
    begin_test();
    vs_high(3);
    send_frame(FW, FH, 8'hE0, 8'h1F);
    chk("resume_done", done_cnt - b_done,    1);
    chk("resume_data", count_bad(8'hE3, 0),  0);
    chk("resume_cnt",  FRAME_CNT,            2);

    // Asynchronous reset with half a pixel pending
    begin_test();
    VSYNC = 1'b0;
    tick();
    tick();
    HREF = 1'b1;
    DATA = 8'hE0;
    tick();
    chk("pre_rst_busy", BUSY, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("arst_wen",  W_EN,      0);
    chk("arst_addr", W_ADDR,    0);
    chk("arst_data", W_DATA,    0);
    chk("arst_cnt",  FRAME_CNT, 0);
    chk("arst_busy", BUSY,      0);
    HREF = 1'b0;
    DATA = 8'h00;
    tick();
    RESET_N = 1'b1;
    // Enable held through the rest of an already-running frame
    repeat (3) send_line(2 * FW, 8'hE0, 8'h1F);
    chk("mid_writes", wr_cnt - b_wr,     0);
    chk("mid_done",   done_cnt - b_done, 0);

    // Odd 7-byte line then a normal line
    begin_test();
    vs_high(3);
    VSYNC = 1'b0;
    tick();
    tick();
    send_line(7, 8'hE0, 8'h1F);
    send_line(2 * FW, 8'hE0, 8'h1F);
    vs_high(3);
    chk("odd_writes", wr_cnt - b_wr, 3 + FW);
    begin
      int n_odd;
      n_odd = 0;
      for (int a = 0; a < 2 * FW; a++) begin
        if (a >= 3 && a < FW) begin
          if (wr_ep[a] == epoch) n_odd++;
        end else if (wr_ep[a] != epoch || mem[a] !== 8'hE3) begin
          n_odd++;
        end
      end
      chk("odd_map", n_odd, 0);
    end
    chk("odd_cnt", FRAME_CNT, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Parametrised OV7670-style camera capture engine. It converts the byte-pair pixel stream (VSYNC/HREF/DATA) into 8-bit pixels and writes them to the dual-port frame buffer. Write addresses are generated row-major, and frame completion is reported to the image processor. It replaces the inline capture logic in the top level and adds:
- selectable input format
- 2:1 decimation
- snapshot mode
- overflow detection
- frame counting

Parameters:
FRAME_WIDTH, 176, stored pixels per row
FRAME_HEIGHT, 144, stored rows per frame
ADDR_WIDTH, 15, write-address width; must satisfy 2^ADDR_WIDTH >= FRAME_WIDTH*FRAME_HEIGHT
CNT_WIDTH, 8, frame counter width

Ports:
CLK  input  1  camera pixel clock (PCLK); the only clock
RESET_N  input  1  asynchronous, active-low reset
CAPTURE_EN  input  1  level; 1 = capture frames
SNAPSHOT  input  1  level, sampled at frame start; 1 = stop after one frame
MODE  input  2  0 RGB565, 1 RGB444, 2 YUV422 luma, 3 test pattern
DECIM_EN  input  1  1 = keep even input pixels of even input rows only
VSYNC  input  1  camera VSYNC, high during vertical blanking
HREF  input  1  camera HREF, high during active line bytes
DATA  input  8  camera data byte
W_EN  output  1  frame-buffer write strobe
W_ADDR  output  ADDR_WIDTH  frame-buffer write address
W_DATA  output  8  pixel, RGB332 or 8-bit grey
FRAME_DONE  output  1  one-cycle pulse when a captured frame ends
FRAME_CNT  output  CNT_WIDTH  completed-frame count, wraps
BUSY  output  1  high in CAPTURE state
OVERFLOW  output  1  sticky, set when a pixel falls outside FRAME_WIDTH x FRAME_HEIGHT

Behaviour:
Reset values:
- All outputs are 0.
- State is IDLE.
- Byte phase is 0.
- All counters are 0.

The asynchronous reset may arrive mid-frame. It aborts the frame with no write issued.

State machine:
- IDLE: go to ARM when CAPTURE_EN=1.
- ARM: go to WAIT_FRAME when VSYNC=1. This guarantees the block never starts mid-frame.
- WAIT_FRAME: on VSYNC=0, latch MODE, DECIM_EN and SNAPSHOT, clear the coordinates, then go to CAPTURE.
- CAPTURE: on VSYNC=1, pulse FRAME_DONE and increment FRAME_CNT. Then:
  - HOLD if the latched SNAPSHOT=1
  - IDLE if CAPTURE_EN=0
  - otherwise WAIT_FRAME
- HOLD: stay until CAPTURE_EN=0, then go to IDLE.
- CAPTURE_EN=0 during CAPTURE does not abort the frame. The frame finishes first.

Byte pairing (CAPTURE state, HREF=1):
- Phase 0 registers the hi byte. Phase 1 takes the lo byte and forms the pixel.
- The phase toggles on every HREF=1 cycle.
- On HREF=0 the phase resets to 0, so an odd trailing byte is discarded.

Conversion:
- RGB565: {hi[7:5], hi[2:0], lo[4:3]}
- RGB444 (xxxxRRRR GGGGBBBB): {hi[3:1], lo[7:5], lo[3:2]}
- YUV422: hi (the Y byte of a YUYV pair)
- Test pattern: out_x[7:0] XOR out_y[7:0], ignoring DATA

Coordinates:
- in_x counts completed pixels per line.
- in_y counts HREF falling edges; the HREF history register is cleared in WAIT_FRAME.
- With DECIM_EN=1, a pixel is kept only if in_x[0]=0 and in_y[0]=0, and out coordinates = in/2.
- With DECIM_EN=0, out = in.

Write rules:
- A kept pixel with out_x<FRAME_WIDTH and out_y<FRAME_HEIGHT produces W_EN=1 for exactly one cycle.
- W_EN asserts on the cycle after the lo byte is sampled (1-cycle latency), with W_ADDR and W_DATA valid in that same cycle.
- A kept pixel outside those bounds produces no write and sets OVERFLOW.
- OVERFLOW is cleared only by reset or the IDLE→ARM transition.

Addressing:
- W_ADDR = row_base + out_x.
- row_base advances by FRAME_WIDTH on each kept line end. No multiplier is allowed.
- out_x restarts at 0 on each line.
- The address never exceeds FRAME_WIDTH*FRAME_HEIGHT-1.

Other:
- FRAME_CNT wraps from 2^CNT_WIDTH-1 to 0.
- If VSYNC rises while HREF=1, the frame ends; a pending half pixel is dropped.

Decomposition:
Package cam_capture_pkg holds:
- MODE encodings (MODE_RGB565, MODE_RGB444, MODE_YUV, MODE_TEST)
- state encodings (IDLE, ARM, WAIT_FRAME, CAPTURE, HOLD)

One sub-module, cam_pixel_convert, is natural: a purely combinational mapping of (mode, hi, lo, out_x, out_y) to an 8-bit pixel. Counters, the FSM and write generation stay in cam_capture_ctrl.

Test Plan:
1. Reset mid-line: assert RESET_N=0 during CAPTURE with half a pixel pending → all outputs 0 immediately; no W_EN after release until a new VSYNC high→low.
2. RGB565, 176x144: bytes hi=0xE0, lo=0x1F per pixel → 25344 writes of 0xE3; last W_ADDR=25343; one FRAME_DONE; FRAME_CNT=1; OVERFLOW=0.
3. MODE=RGB444, DECIM_EN=1, 352x288 input with DATA hi=0x0F, lo=0xF0 → 25344 writes of 0xFC; addresses 0..25343 in order.
4. Oversize frame 180x146 at RGB565 → writes only for x<176, y<144; OVERFLOW=1 after first pixel at x=176; no W_ADDR ≥25344.
5. Snapshot: SNAPSHOT=1, three frames sent → exactly one FRAME_DONE, FRAME_CNT=1, state HOLD; CAPTURE_EN=0 then 1 → capture resumes at the next frame.
6. Odd line of 7 bytes, then CAPTURE_EN raised mid-frame → 3 pixels written, 7th byte dropped, next line phase 0; capture starts only after a full VSYNC high→low.
